// File: rtl/alu_operand_issue_if.sv
// Decode -> execute operand-issue bus: decode operation, forwarding sources and the registered result.
// The DUT takes the slave view; the decode/execute environment takes the master view.
interface alu_operand_issue_if #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int RADDR_W = 5
);
  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [RADDR_W-1:0]         rs1_addr;
  logic [RADDR_W-1:0]         rs2_addr;
  logic [XLEN-1:0]            rs1_data;
  logic [XLEN-1:0]            rs2_data;
  logic [XLEN-1:0]            imm_value;
  logic [XLEN-1:0]            pc;
  logic [1:0]                 a_sel;
  logic [1:0]                 b_sel;
  logic                       is_store;
  logic [NUM_FWD-1:0]         fwd_valid;
  logic [NUM_FWD-1:0]         fwd_pending;
  logic [NUM_FWD*RADDR_W-1:0] fwd_addr;
  logic [NUM_FWD*XLEN-1:0]    fwd_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [XLEN-1:0]            alu_operand1_data;
  logic [XLEN-1:0]            alu_operand2_data;
  logic [XLEN-1:0]            store_data;
  logic [31:0]                stall_count;

  modport slave (
    input  flush, in_valid, rs1_addr, rs2_addr, rs1_data, rs2_data, imm_value, pc,
           a_sel, b_sel, is_store, fwd_valid, fwd_pending, fwd_addr, fwd_data, out_ready,
    output in_ready, out_valid, alu_operand1_data, alu_operand2_data, store_data, stall_count
  );

  modport master (
    output flush, in_valid, rs1_addr, rs2_addr, rs1_data, rs2_data, imm_value, pc,
           a_sel, b_sel, is_store, fwd_valid, fwd_pending, fwd_addr, fwd_data, out_ready,
    input  in_ready, out_valid, alu_operand1_data, alu_operand2_data, store_data, stall_count
  );
endinterface

// File: rtl/alu_operand_issue.sv
// ALU operand select + forwarding + load-use stall, registered into a valid/ready stage.
// Optional stall-cycle counter enabled by defining ALU_OPERAND_STALL_STATS_EN.

// One register operand resolved against all forwarding sources; index 0 wins.
module alu_operand_issue_fwd #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int RADDR_W = 5
) (
  input  logic [RADDR_W-1:0]         rs_addr,
  input  logic [XLEN-1:0]            rs_data,
  input  logic [NUM_FWD-1:0]         fwd_valid,
  input  logic [NUM_FWD-1:0]         fwd_pending,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0]    fwd_data,
  output logic [XLEN-1:0]            opr_data,
  output logic                       hazard
);
  logic hit;

  always_comb begin
    hit      = 1'b0;
    opr_data = rs_data;
    hazard   = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!hit && rs_addr != '0 && fwd_valid[i] &&
          fwd_addr[i*RADDR_W +: RADDR_W] == rs_addr) begin
        hit      = 1'b1;
        opr_data = fwd_data[i*XLEN +: XLEN];
        hazard   = fwd_pending[i];
      end
    end
  end
endmodule

module alu_operand_issue #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int RADDR_W = 5
) (
  input logic                clk,
  input logic                rst_n,
  alu_operand_issue_if.slave bus
);
  localparam int NUM_OPR = 2;  // lane 0 = rs1, lane 1 = rs2

  logic [NUM_OPR-1:0][RADDR_W-1:0] rs_addr;
  logic [NUM_OPR-1:0][XLEN-1:0]    rs_data;
  logic [NUM_OPR-1:0][XLEN-1:0]    rs_fwd;
  logic [NUM_OPR-1:0]              rs_haz;

  assign rs_addr = {bus.rs2_addr, bus.rs1_addr};
  assign rs_data = {bus.rs2_data, bus.rs1_data};

  for (genvar g = 0; g < NUM_OPR; g++) begin : g_opr
    alu_operand_issue_fwd #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .RADDR_W(RADDR_W)) u_fwd (
      .rs_addr     (rs_addr[g]),
      .rs_data     (rs_data[g]),
      .fwd_valid   (bus.fwd_valid),
      .fwd_pending (bus.fwd_pending),
      .fwd_addr    (bus.fwd_addr),
      .fwd_data    (bus.fwd_data),
      .opr_data    (rs_fwd[g]),
      .hazard      (rs_haz[g])
    );
  end

  logic            use_rs1, use_rs2, hazard, in_ready, capture;
  logic [XLEN-1:0] opa, opb;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d, st_q, st_d;

  always_comb begin
    use_rs1  = (bus.a_sel == 2'b00);
    use_rs2  = (bus.b_sel == 2'b00) || bus.is_store;
    hazard   = bus.in_valid && ((use_rs1 && rs_haz[0]) || (use_rs2 && rs_haz[1]));
    in_ready = !bus.flush && !hazard && (!out_valid_q || bus.out_ready);
    capture  = bus.in_valid && in_ready;

    unique case (bus.a_sel)
      2'b00:   opa = rs_fwd[0];
      2'b01:   opa = bus.pc;
      default: opa = '0;
    endcase
    unique case (bus.b_sel)
      2'b00:   opb = rs_fwd[1];
      2'b01:   opb = bus.imm_value;
      2'b10:   opb = XLEN'(4);
      default: opb = '0;
    endcase

    // capture implies !flush, so flush only needs to kill the valid bit
    out_valid_d = out_valid_q;
    if (bus.flush)          out_valid_d = 1'b0;
    else if (capture)       out_valid_d = 1'b1;
    else if (bus.out_ready) out_valid_d = 1'b0;

    op1_d = capture ? opa       : op1_q;
    op2_d = capture ? opb       : op2_q;
    st_d  = capture ? rs_fwd[1] : st_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      st_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      st_q        <= st_d;
    end
  end

  assign bus.in_ready          = in_ready;
  assign bus.out_valid         = out_valid_q;
  assign bus.alu_operand1_data = op1_q;
  assign bus.alu_operand2_data = op2_q;
  assign bus.store_data        = st_q;

`ifdef ALU_OPERAND_STALL_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.in_valid && !in_ready && !bus.flush && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_count = stall_cnt_q;
`else
  assign bus.stall_count = '0;
`endif
endmodule

// File: doc/alu_operand_issue.md
# alu_operand_issue

Registered ALU operand select and forwarding stage at the decode/execute boundary of the RV32I core. It picks ALU operand A (register, PC or zero) and operand B (register, immediate or constant 4), resolves register operands against a parametrised set of forwarding sources, and stalls on load-use hazards. Results are captured into a valid/ready pipeline register that feeds the execute stage.

## Interface
Parameters:
- XLEN, 32, datapath width.
- NUM_FWD, 2, number of forwarding sources. Index 0 is the youngest source and has highest priority.
- RADDR_W, 5, register address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  kill the held and incoming operation.
- in_valid  in  1  decode has an operation.
- in_ready  out  1  stage accepts this cycle.
- rs1_addr, rs2_addr  in  RADDR_W  source register indices.
- rs1_data, rs2_data  in  XLEN  register-file read data.
- imm_value  in  XLEN  decoded immediate.
- pc  in  XLEN  instruction address.
- a_sel  in  2  operand A select: 00 reg, 01 pc, 10 zero, 11 zero.
- b_sel  in  2  operand B select: 00 reg, 01 imm, 10 constant 4, 11 zero.
- is_store  in  1  rs2 is consumed as store data.
- fwd_valid  in  NUM_FWD  source writes a register.
- fwd_pending  in  NUM_FWD  source's data is not yet available (load in flight).
- fwd_addr  in  NUM_FWD*RADDR_W  destination indices, packed with index 0 at the LSBs.
- fwd_data  in  NUM_FWD*XLEN  write data, packed with index 0 at the LSBs.
- out_valid  out  1  registered operation valid.
- out_ready  in  1  execute accepts.
- alu_operand1_data, alu_operand2_data  out  XLEN  registered operands.
- store_data  out  XLEN  registered, forwarded rs2.
- stall_count  out  32  stall-cycle counter.

## Operation
- Forwarding for each register operand:
  - Select the lowest index i with fwd_valid[i] set and fwd_addr[i] == rs_addr.
  - If rs_addr == 0, nothing matches.
  - If there is no match, use the register-file data.
  - If the match has fwd_pending[i] set, that operand is hazarded. Older, non-pending matches are ignored.
- When each operand is used:
  - rs1 is used when a_sel == 00.
  - rs2 is used when b_sel == 00 or is_store is set.
- hazard = in_valid and (a used and hazarded operand, or a used and hazarded rs2).
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Capture happens when in_valid && in_ready. On capture, the operands and store_data are loaded from the forwarded values and out_valid becomes 1.
- out_valid clears when out_ready is high and there is no capture in the same cycle.
- While out_valid && !out_ready, the output registers hold stable.
- flush has priority over everything: out_valid becomes 0 on the next edge, nothing is captured, and in_ready is 0. The data registers keep their contents.
- Operand widths are all XLEN. The constant 4 is zero-extended. No arithmetic is performed here.

## Timing
- Latency: 1 cycle from capture to out_valid.
- Throughput: 1 operation per cycle when out_ready is held high.
- Reset: out_valid=0, alu_operand1_data=0, alu_operand2_data=0, store_data=0, stall_count=0. Reset asserted mid-operation drops the held operation.
- in_ready is combinational from flush, the hazard inputs, out_valid and out_ready.
- Simultaneous capture and drain: the register reloads in the same edge and out_valid stays 1.
- A hazard persists until fwd_pending clears or the matching fwd_valid drops. Capture then happens on that same cycle's edge using the then-current fwd_data.

## Configuration
- ALU_OPERAND_STALL_STATS_EN defined:
  - stall_count increments on every edge where in_valid && !in_ready && !flush.
  - It saturates at 0xFFFF_FFFF.
- Not defined: stall_count is constant 0 and no counter logic is built.

## Test plan
- Reset, then in_valid with a_sel=00, b_sel=01, rs1_data=0x10, imm=0x5, no forwarding -> next cycle out_valid=1, operand1=0x10, operand2=0x5.
- Forward priority: rs1_addr=3, both sources valid with addr 3, fwd_data[0]=0xAA and [1]=0xBB -> operand1=0xAA. Same with rs1_addr=0 -> operand1=rs1_data.
- Load-use: fwd_pending[0]=1 on rs2=7 with b_sel=00 -> in_ready=0 for 2 cycles. Clear pending with fwd_data[0]=0x77 -> captured operand2=0x77. With the macro defined, stall_count=2.
- Backpressure: out_ready=0 for 3 cycles with new input waiting -> outputs hold and in_ready=0. Raising out_ready gives back-to-back transfer with no bubble.
- flush while out_valid=1 and in_valid=1 -> next cycle out_valid=0 and the input is not captured.
- Store with b_sel=01 and rs2 forwarded from index 1 (0x1234) -> store_data=0x1234, operand2=imm.
